// File: rtl/pipe_adder.sv
// pipe_adder: carry-chunked pipelined adder with valid/ready flow control.
//
// The WIDTH-bit addition is split into STAGES = WIDTH/CHUNK slices. Stage k
// adds operand bits [k*CHUNK +: CHUNK] using the carry registered by stage
// k-1, so the longest combinational carry chain is CHUNK bits. Each stage
// registers its valid bit, the completed low sum bits, its carry-out and the
// operand bits that later stages still have to add.
//
// The whole pipeline moves together on advance = !out_valid || out_ready.
// This means a stall at the output freezes every stage, and an idle input
// slot becomes a bubble.
//
// Optional feature: define PIPE_ADDER_OVF_EN to add output ovf. This is the
// signed two's-complement overflow of the result, registered alongside sum.
module pipe_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    // Global pipeline enable: the output slot is empty or is being drained.
    logic advance_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : gen_stage
            // Operand bits still to be added when entering this stage.
            localparam int IW = WIDTH - k * CHUNK;
            // Sum bits that are complete once this stage has added its slice.
            localparam int OW = (k + 1) * CHUNK;

            logic           vld_in_s;
            logic           cry_in_s;
            logic [IW-1:0]  opa_in_s;
            logic [IW-1:0]  opb_in_s;
            logic [CHUNK:0] add_s;
            logic [OW-1:0]  sum_nxt_s;
            logic           vld_r;
            logic           cry_r;
            logic [OW-1:0]  sum_r;

            if (k == 0) begin : gen_head
                // The first stage takes the beat straight from the input port.
                assign vld_in_s  = in_valid;
                assign cry_in_s  = cin;
                assign opa_in_s  = a;
                assign opb_in_s  = b;
                assign sum_nxt_s = add_s[CHUNK-1:0];
            end else begin : gen_body
                // Later stages take the previous stage's registered state.
                assign vld_in_s  = gen_stage[k-1].vld_r;
                assign cry_in_s  = gen_stage[k-1].cry_r;
                assign opa_in_s  = gen_stage[k-1].gen_rem.opa_r;
                assign opb_in_s  = gen_stage[k-1].gen_rem.opb_r;
                assign sum_nxt_s = {add_s[CHUNK-1:0], gen_stage[k-1].sum_r};
            end

            // CHUNK-bit slice adder. This is the only carry chain in the stage.
            assign add_s = {1'b0, opa_in_s[CHUNK-1:0]}
                         + {1'b0, opb_in_s[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, cry_in_s};

            // Stage valid, carry and finished low sum bits. These are held
            // while the pipeline is stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= 1'b0;
                    cry_r <= 1'b0;
                    sum_r <= {OW{1'b0}};
                end else if (advance_s) begin
                    vld_r <= vld_in_s;
                    cry_r <= add_s[CHUNK];
                    sum_r <= sum_nxt_s;
                end
            end

            if (k < STAGES - 1) begin : gen_rem
                logic [IW-CHUNK-1:0] opa_r;
                logic [IW-CHUNK-1:0] opb_r;

                // Carry forward the operand bits that downstream stages still add.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        opa_r <= {(IW-CHUNK){1'b0}};
                        opb_r <= {(IW-CHUNK){1'b0}};
                    end else if (advance_s) begin
                        opa_r <= opa_in_s[IW-1:CHUNK];
                        opb_r <= opb_in_s[IW-1:CHUNK];
                    end
                end
            end
        end
    endgenerate

    // The outputs are driven directly by the registers of the last stage.
    assign out_valid = gen_stage[STAGES-1].vld_r;
    assign sum       = gen_stage[STAGES-1].sum_r;
    assign cout      = gen_stage[STAGES-1].cry_r;

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow: carry into the MSB xor carry out of the MSB. The carry
    // into the MSB is recovered as a_msb ^ b_msb ^ sum_msb.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic c_out
    );
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    logic ovf_r;

    // Overflow flag, computed in the last stage and moved with sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            ovf_r <= signed_ovf(gen_stage[STAGES-1].opa_in_s[CHUNK-1],
                                gen_stage[STAGES-1].opb_in_s[CHUNK-1],
                                gen_stage[STAGES-1].sum_nxt_s[WIDTH-1],
                                gen_stage[STAGES-1].add_s[CHUNK]);
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of the WIDTH=8/CHUNK=2 pipelined adder
// (latency 4), plus a CHUNK=8 single-stage instance and a random
// valid/ready soak compared against a plain a+b+cin reference.
module tb_pipe_adder;

    logic       clk_s = 1'b0;
    logic       rst_n_s;
    logic       in_valid_s;
    logic       in_ready_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       cin_s;
    logic       out_valid_s;
    logic       out_ready_s;
    logic [7:0] sum_s;
    logic       cout_s;

    logic       in_valid8_s;
    logic       in_ready8_s;
    logic [7:0] a8_s;
    logic [7:0] b8_s;
    logic       cin8_s;
    logic       out_valid8_s;
    logic       out_ready8_s;
    logic [7:0] sum8_s;
    logic       cout8_s;
`ifdef PIPE_ADDER_OVF_EN
    logic       ovf_s;
    logic       ovf8_s;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    localparam int RAND_BEATS = 10000;

    // 10 ns clock.
    always #5 clk_s = ~clk_s;

    pipe_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk       (clk_s),
        .rst_n     (rst_n_s),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .a         (a_s),
        .b         (b_s),
        .cin       (cin_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .sum       (sum_s),
        .cout      (cout_s)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf_s)
`endif
    );

    pipe_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk_s),
        .rst_n     (rst_n_s),
        .in_valid  (in_valid8_s),
        .in_ready  (in_ready8_s),
        .a         (a8_s),
        .b         (b8_s),
        .cin       (cin8_s),
        .out_valid (out_valid8_s),
        .out_ready (out_ready8_s),
        .sum       (sum8_s),
        .cout      (cout8_s)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf8_s)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        in_valid_s = v;
        a_s        = av;
        b_s        = bv;
        cin_s      = cv;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] s, input logic c);
        chk1({tag, "_valid"}, out_valid_s, v);
        if (v) begin
            chk8({tag, "_sum"}, sum_s, s);
            chk1({tag, "_cout"}, cout_s, c);
        end
    endtask

    initial begin
        logic [8:0] sb_q[$];
        int         accepted;
        int         got;

        rst_n_s      = 1'b0;
        out_ready_s  = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        in_valid8_s  = 1'b0;
        a8_s         = 8'h00;
        b8_s         = 8'h00;
        cin8_s       = 1'b0;
        out_ready8_s = 1'b0;

        // Reset state before any clock edge.
        #3;
        chk1("rst_out_valid", out_valid_s, 1'b0);
        chk8("rst_sum", sum_s, 8'h00);
        chk1("rst_cout", cout_s, 1'b0);
        chk1("rst_in_ready", in_ready_s, 1'b1);
        chk1("rst_out_valid8", out_valid8_s, 1'b0);

        // Release reset, then accept on the very first rising edge: FF+01.
        @(negedge clk_s);
        rst_n_s     = 1'b1;
        out_ready_s = 1'b1;
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        #1;
        chk1("first_in_ready", in_ready_s, 1'b1);
        step();
        chk1("lat1_valid", out_valid_s, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        chk1("lat2_valid", out_valid_s, 1'b0);
        step();
        chk1("lat3_valid", out_valid_s, 1'b0);
        step();
        expect_out("wrap", 1'b1, 8'h00, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
        chk1("wrap_ovf", ovf_s, 1'b0);
`endif
        step();
        chk1("bubble_valid", out_valid_s, 1'b0);

        // Back-to-back beats: 7F+01+0 then 80+80+1.
        drive(1'b1, 8'h7F, 8'h01, 1'b0);
        step();
        drive(1'b1, 8'h80, 8'h80, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        expect_out("b2b0", 1'b1, 8'h80, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
        chk1("b2b0_ovf", ovf_s, 1'b1);
`endif
        step();
        expect_out("b2b1", 1'b1, 8'h01, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
        chk1("b2b1_ovf", ovf_s, 1'b1);
`endif
        step();
        chk1("b2b_drained", out_valid_s, 1'b0);

        // Four beats in flight, then the output stalls.
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        step();
        drive(1'b1, 8'h10, 8'h20, 1'b1);
        step();
        drive(1'b1, 8'hF0, 8'hF0, 1'b0);
        step();
        drive(1'b1, 8'hAA, 8'h55, 1'b1);
        out_ready_s = 1'b0;
        step();
        expect_out("stall_first", 1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        #1;
        chk1("stall_in_ready", in_ready_s, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("stall_hold", 1'b1, 8'h03, 1'b0);
            chk1("stall_hold_in_ready", in_ready_s, 1'b0);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        out_ready_s = 1'b1;
        #1;
        chk1("release_in_ready", in_ready_s, 1'b1);
        step();
        expect_out("release1", 1'b1, 8'h31, 1'b0);
        step();
        expect_out("release2", 1'b1, 8'hE0, 1'b1);
        step();
        expect_out("release3", 1'b1, 8'h00, 1'b1);
        step();
        chk1("release_drained", out_valid_s, 1'b0);

        // Reset with three beats in flight.
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        step();
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        step();
        drive(1'b1, 8'h55, 8'h66, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        out_ready_s = 1'b0;
        step();
        expect_out("pre_reset", 1'b1, 8'h33, 1'b0);
        #2;
        rst_n_s = 1'b0;
        #1;
        chk1("midrst_valid", out_valid_s, 1'b0);
        chk8("midrst_sum", sum_s, 8'h00);
        chk1("midrst_cout", cout_s, 1'b0);
        chk1("midrst_in_ready", in_ready_s, 1'b1);
        #2;
        rst_n_s     = 1'b1;
        out_ready_s = 1'b1;
        drive(1'b1, 8'h01, 8'h01, 1'b0);
        step();
        chk1("postrst_valid1", out_valid_s, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        chk1("postrst_valid2", out_valid_s, 1'b0);
        step();
        chk1("postrst_valid3", out_valid_s, 1'b0);
        step();
        expect_out("postrst", 1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("postrst_no_ghost", out_valid_s, 1'b0);
        end

        // Single-stage build: latency 1.
        chk1("c8_idle", out_valid8_s, 1'b0);
        in_valid8_s  = 1'b1;
        a8_s         = 8'h12;
        b8_s         = 8'h34;
        cin8_s       = 1'b1;
        out_ready8_s = 1'b1;
        step();
        chk1("c8_valid", out_valid8_s, 1'b1);
        chk8("c8_sum", sum8_s, 8'h47);
        chk1("c8_cout", cout8_s, 1'b0);
        a8_s   = 8'hFF;
        b8_s   = 8'h00;
        cin8_s = 1'b1;
        step();
        chk1("c8_wrap_valid", out_valid8_s, 1'b1);
        chk8("c8_wrap_sum", sum8_s, 8'h00);
        chk1("c8_wrap_cout", cout8_s, 1'b1);
        in_valid8_s = 1'b0;
        step();
        chk1("c8_bubble", out_valid8_s, 1'b0);

        // Random traffic against the a+b+cin reference, order-checked.
        accepted = 0;
        got      = 0;
        for (int cyc = 0; cyc < 60000 && got < RAND_BEATS; cyc++) begin
            step();
            if (accepted < RAND_BEATS && $urandom_range(0, 3) != 0) begin
                drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                drive(1'b0, 8'h00, 8'h00, 1'b0);
            end
            out_ready_s = ($urandom_range(0, 3) != 0);
            @(negedge clk_s);
            if (out_valid_s && out_ready_s) begin
                got++;
                if (sb_q.size() > 0) begin
                    check("rand_result", 64'({cout_s, sum_s}), 64'(sb_q.pop_front()));
                end else begin
                    chki("rand_spurious_queue", sb_q.size(), 1);
                end
            end
            if (in_valid_s && in_ready_s) begin
                sb_q.push_back({1'b0, a_s} + {1'b0, b_s} + {8'h00, cin_s});
                accepted++;
            end
        end
        chki("rand_accepted", accepted, RAND_BEATS);
        chki("rand_count", got, RAND_BEATS);
        chki("rand_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
